// File: rtl/video_cap_pkg.sv
// rtl/video_cap_pkg.sv - shared types, pattern codes, bar colours and widths for the video test pattern generator
package video_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HBLANK = 2'd3
  } tpg_state_e;

  typedef enum logic [1:0] {
    PAT_BARS   = 2'd0,
    PAT_RAMP   = 2'd1,
    PAT_MOVING = 2'd2,
    PAT_SOLID  = 2'd3
  } pattern_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  localparam int H_ACTIVE_DEF = 1920;
  localparam int V_ACTIVE_DEF = 1080;
  localparam int V_BLANK_DEF  = 45000;

  localparam int X_W     = $clog2(H_ACTIVE_DEF);
  localparam int Y_W     = $clog2(V_ACTIVE_DEF);
  localparam int BLANK_W = $clog2(V_BLANK_DEF);

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_cap_tpg_pattern.sv
// rtl/video_cap_tpg_pattern.sv - combinational pixel function for the test pattern generator
module video_cap_tpg_pattern
  import video_cap_pkg::*;
(
  input  pattern_e    pattern,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [2:0]  bar_idx,
  input  logic [7:0]  frame_cnt,
  input  logic [23:0] solid,
  output logic [23:0] pixel
);

  always_comb begin
    pixel = '0;
    case (pattern)
      PAT_BARS:   pixel = bar_colour(bar_idx);
      PAT_RAMP:   pixel = {x, x, x};
      PAT_MOVING: pixel = {frame_cnt, y, x};
      default:    pixel = solid;
    endcase
  end

endmodule

// File: rtl/video_cap_tpg.sv
// rtl/video_cap_tpg.sv - synthetic AXI4-Stream video source with SOF/EOL framing and VSYNC
module video_cap_tpg
  import video_cap_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int H_BLANK      = 280,
  parameter int V_BLANK      = V_BLANK_DEF,
  parameter int VSYNC_CYCLES = 200
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic        ctrl_enable,
  input  logic        ctrl_soft_reset,
  input  logic [1:0]  ctrl_pattern,
  input  logic [23:0] ctrl_solid_rgb,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        vid_vsync,
  output logic [15:0] sts_frame_cnt,
  output logic        sts_busy
);

  localparam logic [X_W-1:0]     X_LAST   = X_W'(H_ACTIVE - 1);
  localparam logic [X_W-1:0]     BAR_LAST = X_W'(H_ACTIVE / 8 - 1);
  localparam logic [Y_W-1:0]     Y_LAST   = Y_W'(V_ACTIVE - 1);
  localparam logic [BLANK_W-1:0] VB_LAST  = BLANK_W'(V_BLANK - 1);
  localparam logic [BLANK_W-1:0] HB_LAST  = BLANK_W'(H_BLANK - 1);
  localparam logic [BLANK_W-1:0] VS_LAST  = BLANK_W'(VSYNC_CYCLES - 1);
  localparam logic               VSYNC_ON = (VSYNC_CYCLES > 0);

  tpg_state_e          state, state_d;
  logic [X_W-1:0]      x, x_d, bar_cnt, bar_cnt_d;
  logic [Y_W-1:0]      y, y_d;
  logic [2:0]          bar_idx, bar_idx_d;
  logic [BLANK_W-1:0]  blank_cnt, blank_cnt_d;
  logic [15:0]         frame_cnt, frame_cnt_d;
  pattern_e            pat_q, pat_d, pat_src;
  logic [23:0]         solid_q, solid_d, solid_src, pixel;
  logic                tvalid_d, tlast_d, tuser_d, vsync_d, load, hs;

  assign hs            = m_axis_tvalid && m_axis_tready;
  assign sts_frame_cnt = frame_cnt;
  assign sts_busy      = (state != ST_IDLE);

  // x_d/y_d/bar_idx_d always name the beat that gets loaded when load is set
  always_comb begin
    state_d     = state;
    x_d         = x;
    y_d         = y;
    bar_idx_d   = bar_idx;
    bar_cnt_d   = bar_cnt;
    blank_cnt_d = blank_cnt;
    frame_cnt_d = frame_cnt;
    pat_d       = pat_q;
    solid_d     = solid_q;
    pat_src     = pat_q;
    solid_src   = solid_q;
    tvalid_d    = m_axis_tvalid;
    tlast_d     = m_axis_tlast;
    tuser_d     = m_axis_tuser;
    vsync_d     = 1'b0;
    load        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (ctrl_enable) begin
          state_d     = ST_VBLANK;
          blank_cnt_d = '0;
          vsync_d     = VSYNC_ON;
        end
      end

      ST_VBLANK: begin
        vsync_d   = VSYNC_ON && (blank_cnt < VS_LAST);
        pat_src   = pattern_e'(ctrl_pattern);
        solid_src = ctrl_solid_rgb;
        if (blank_cnt == VB_LAST) begin
          state_d = ST_ACTIVE;
          pat_d   = pattern_e'(ctrl_pattern);
          solid_d = ctrl_solid_rgb;
          load    = 1'b1;
        end else begin
          blank_cnt_d = blank_cnt + 1'b1;
        end
      end

      ST_HBLANK: begin
        if (blank_cnt == HB_LAST) begin
          state_d = ST_ACTIVE;
          load    = 1'b1;
        end else begin
          blank_cnt_d = blank_cnt + 1'b1;
        end
      end

      default: begin
        if (hs) begin
          if (x == X_LAST) begin
            x_d       = '0;
            bar_idx_d = '0;
            bar_cnt_d = '0;
            if (y == Y_LAST) begin
              y_d         = '0;
              frame_cnt_d = frame_cnt + 16'd1;
              blank_cnt_d = '0;
              tvalid_d    = 1'b0;
              tlast_d     = 1'b0;
              tuser_d     = 1'b0;
              if (ctrl_enable) begin
                state_d = ST_VBLANK;
                vsync_d = VSYNC_ON;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              y_d = y + 1'b1;
              if (H_BLANK == 0) begin
                load = 1'b1;
              end else begin
                state_d     = ST_HBLANK;
                blank_cnt_d = '0;
                tvalid_d    = 1'b0;
                tlast_d     = 1'b0;
                tuser_d     = 1'b0;
              end
            end
          end else begin
            x_d  = x + 1'b1;
            load = 1'b1;
            if (bar_cnt == BAR_LAST) begin
              bar_idx_d = bar_idx + 3'd1;
              bar_cnt_d = '0;
            end else begin
              bar_cnt_d = bar_cnt + 1'b1;
            end
          end
        end
      end
    endcase

    if (load) begin
      tvalid_d = 1'b1;
      tlast_d  = (x_d == X_LAST);
      tuser_d  = (x_d == '0) && (y_d == '0);
    end
  end

  video_cap_tpg_pattern u_pattern (
    .pattern   (pat_src),
    .x         (x_d[7:0]),
    .y         (y_d[7:0]),
    .bar_idx   (bar_idx_d),
    .frame_cnt (frame_cnt[7:0]),
    .solid     (solid_src),
    .pixel     (pixel)
  );

  // soft reset aborts mid-beat; only safe because the bridge shares it
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn || ctrl_soft_reset) begin
      state         <= ST_IDLE;
      x             <= '0;
      y             <= '0;
      bar_idx       <= '0;
      bar_cnt       <= '0;
      blank_cnt     <= '0;
      frame_cnt     <= '0;
      pat_q         <= PAT_BARS;
      solid_q       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      vid_vsync     <= 1'b0;
    end else begin
      state         <= state_d;
      x             <= x_d;
      y             <= y_d;
      bar_idx       <= bar_idx_d;
      bar_cnt       <= bar_cnt_d;
      blank_cnt     <= blank_cnt_d;
      frame_cnt     <= frame_cnt_d;
      pat_q         <= pat_d;
      solid_q       <= solid_d;
      m_axis_tvalid <= tvalid_d;
      m_axis_tlast  <= tlast_d;
      m_axis_tuser  <= tuser_d;
      vid_vsync     <= vsync_d;
      if (load) m_axis_tdata <= pixel;
    end
  end

endmodule

// File: tb/tb_video_cap_tpg.sv
// tb/tb_video_cap_tpg.sv - directed self-checking bench for video_cap_tpg
module tb_video_cap_tpg;

  logic        axi_aclk = 1'b0;
  logic        axi_aresetn;
  logic        ctrl_enable;
  logic        ctrl_soft_reset;
  logic [1:0]  ctrl_pattern;
  logic [23:0] ctrl_solid_rgb;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        vid_vsync;
  logic [15:0] sts_frame_cnt;
  logic        sts_busy;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          stall_err = 0;
  int          nb = 0;
  logic [23:0] bd [64];
  logic        bl [64];
  logic        bu [64];
  int          bcyc [64];
  int          n, vm;
  logic        acc;

  always #5 axi_aclk = ~axi_aclk;

  video_cap_tpg #(
    .H_ACTIVE     (8),
    .V_ACTIVE     (4),
    .H_BLANK      (2),
    .V_BLANK      (6),
    .VSYNC_CYCLES (2)
  ) dut (
    .axi_aclk        (axi_aclk),
    .axi_aresetn     (axi_aresetn),
    .ctrl_enable     (ctrl_enable),
    .ctrl_soft_reset (ctrl_soft_reset),
    .ctrl_pattern    (ctrl_pattern),
    .ctrl_solid_rgb  (ctrl_solid_rgb),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tuser    (m_axis_tuser),
    .vid_vsync       (vid_vsync),
    .sts_frame_cnt   (sts_frame_cnt),
    .sts_busy        (sts_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge axi_aclk);
    #1;
    cyc++;
  endtask

  function automatic logic [23:0] exp_pix(input int pat, input int x, input int y, input int f);
    case (pat)
      0:       return BARS[x];
      1:       return {8'(x), 8'(x), 8'(x)};
      2:       return {8'(f), 8'(y), 8'(x)};
      default: return ctrl_solid_rgb;
    endcase
  endfunction

  // steps until tvalid is seen; vm bit k holds vsync as sampled k clocks after the call
  task automatic wait_valid(output int cnt, output int mask);
    cnt  = 0;
    mask = 0;
    while (1) begin
      mask = mask | (int'(vid_vsync) << cnt);
      if (m_axis_tvalid || cnt >= 64) break;
      step();
      cnt++;
    end
  endtask

  task automatic collect(input int want, input bit rnd);
    int          got = 0;
    int          spent = 0;
    logic [23:0] hd;
    logic        hl, hu, held;
    while (got < want && spent < want * 8 + 64) begin
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      held = m_axis_tvalid && !m_axis_tready;
      hd = m_axis_tdata;
      hl = m_axis_tlast;
      hu = m_axis_tuser;
      if (m_axis_tvalid && m_axis_tready) begin
        bd[nb]   = m_axis_tdata;
        bl[nb]   = m_axis_tlast;
        bu[nb]   = m_axis_tuser;
        bcyc[nb] = cyc;
        nb++;
        got++;
      end
      step();
      spent++;
      if (held && (!m_axis_tvalid || m_axis_tdata !== hd || m_axis_tlast !== hl || m_axis_tuser !== hu))
        stall_err++;
    end
    chk("beat count", got, want);
    m_axis_tready = 1'b1;
  endtask

  task automatic check_frame(input string tag, input int pat, input int f);
    for (int i = 0; i < nb; i++) begin
      int x = i % 8;
      int y = i / 8;
      chk($sformatf("%s data x%0d y%0d", tag, x, y), bd[i], exp_pix(pat, x, y, f));
      chk($sformatf("%s last/user x%0d y%0d", tag, x, y), {bl[i], bu[i]}, {(x == 7), (i == 0)});
    end
  endtask

  initial begin
    axi_aresetn     = 1'b0;
    ctrl_enable     = 1'b0;
    ctrl_soft_reset = 1'b0;
    ctrl_pattern    = 2'd0;
    ctrl_solid_rgb  = 24'h123456;
    m_axis_tready   = 1'b1;
    repeat (3) step();
    chk("rst tvalid", m_axis_tvalid, 0);
    chk("rst flags", {m_axis_tlast, m_axis_tuser, vid_vsync, sts_busy}, 0);
    chk("rst tdata", m_axis_tdata, 0);
    chk("rst frame_cnt", sts_frame_cnt, 0);
    axi_aresetn = 1'b1;
    step();
    chk("idle busy", sts_busy, 0);

    // colour bars from enable
    ctrl_enable = 1'b1;
    wait_valid(n, vm);
    chk("enable latency", n, 7);
    chk("enable vsync", vm, 32'h6);
    chk("busy running", sts_busy, 1);
    nb = 0;
    collect(32, 1'b0);
    check_frame("bars", 0, 0);
    chk("hgap line0-1", bcyc[8] - bcyc[7], 3);
    chk("hgap line2-3", bcyc[24] - bcyc[23], 3);
    chk("frame_cnt after bars", sts_frame_cnt, 1);

    // ramp with random backpressure
    ctrl_pattern = 2'd1;
    wait_valid(n, vm);
    chk("vgap bars-ramp", n, 6);
    chk("vgap vsync", vm, 32'h3);
    nb = 0;
    collect(32, 1'b1);
    check_frame("ramp", 1, 0);
    chk("stall stable", stall_err, 0);
    wait_valid(n, vm);
    chk("vgap after stalls", n, 6);

    // soft reset at x=4,y=1
    nb = 0;
    collect(12, 1'b0);
    chk("pre-abort beat", m_axis_tdata, 24'h040404);
    chk("pre-abort frame_cnt", sts_frame_cnt, 2);
    ctrl_soft_reset = 1'b1;
    step();
    ctrl_soft_reset = 1'b0;
    ctrl_pattern = 2'd2;
    chk("abort tvalid", m_axis_tvalid, 0);
    chk("abort frame_cnt", sts_frame_cnt, 0);
    chk("abort busy", sts_busy, 0);
    wait_valid(n, vm);
    chk("restart latency", n, 7);
    chk("restart vsync", vm, 32'h6);
    chk("restart first beat", {m_axis_tuser, m_axis_tdata}, {1'b1, 24'h000000});

    // moving pattern, switch to ramp mid frame 2
    nb = 0;
    collect(32, 1'b0);
    check_frame("moving f1", 2, 0);
    wait_valid(n, vm);
    nb = 0;
    collect(20, 1'b0);
    ctrl_pattern = 2'd1;
    collect(12, 1'b0);
    check_frame("moving f2", 2, 1);
    chk("moving f2 x3 y2", bd[19], 24'h010203);
    wait_valid(n, vm);
    chk("vgap f2-f3", n, 6);
    nb = 0;
    collect(32, 1'b0);
    check_frame("ramp f3", 1, 2);
    chk("frame_cnt after 3", sts_frame_cnt, 3);

    // disable on line 1
    wait_valid(n, vm);
    nb = 0;
    collect(8, 1'b0);
    ctrl_enable = 1'b0;
    collect(24, 1'b0);
    check_frame("disable", 1, 3);
    chk("disable busy", sts_busy, 0);
    chk("disable frame_cnt", sts_frame_cnt, 4);
    acc = 1'b0;
    repeat (12) begin
      acc = acc | m_axis_tvalid | vid_vsync | sts_busy;
      step();
    end
    chk("idle quiet", acc, 0);
    chk("stall stable final", stall_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
